// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO stream reader: FSM encoding, holding-buffer depth
// and the pop-issue room check.
package fifo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } reader_state_t;

    localparam int unsigned HOLD_DEPTH = 2;
    localparam int unsigned OCC_WIDTH  = $clog2(HOLD_DEPTH + 1);

    // Words already committed to the holding buffer (held + in flight - leaving now)
    // must leave space for one more pop.
    function automatic logic has_room(
        input logic [OCC_WIDTH-1:0] occupancy,
        input logic                 pending,
        input logic                 pop
    );
        logic [OCC_WIDTH:0] committed;
        committed = {1'b0, occupancy}
                  + {{OCC_WIDTH{1'b0}}, pending}
                  - {{OCC_WIDTH{1'b0}}, pop};
        return committed < (OCC_WIDTH + 1)'(HOLD_DEPTH);
    endfunction

endpackage

// File: rtl/fifo_skid_buffer.sv
// Two-entry holding buffer: an output register plus a skid register behind it,
// presenting a registered valid/ready stream and strict FIFO ordering.
module fifo_skid_buffer
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  ready,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    output logic [OCC_WIDTH-1:0]  occupancy
);

    logic                  out_valid, out_valid_next;
    logic [DATA_WIDTH-1:0] out_data, out_data_next;
    logic                  skid_valid, skid_valid_next;
    logic [DATA_WIDTH-1:0] skid_data, skid_data_next;
    logic                  pop;

    assign pop = out_valid & ready;

    always_comb begin
        out_valid_next  = out_valid;
        out_data_next   = out_data;
        skid_valid_next = skid_valid;
        skid_data_next  = skid_data;

        if (pop) begin
            if (skid_valid) begin
                out_data_next   = skid_data;
                skid_valid_next = 1'b0;
            end else begin
                out_valid_next = 1'b0;
            end
        end

        // The incoming word lands behind whatever survives this cycle's pop.
        if (push) begin
            if (!out_valid_next) begin
                out_valid_next = 1'b1;
                out_data_next  = push_data;
            end else begin
                skid_valid_next = 1'b1;
                skid_data_next  = push_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else begin
            out_valid  <= out_valid_next;
            out_data   <= out_data_next;
            skid_valid <= skid_valid_next;
            skid_data  <= skid_data_next;
        end
    end

    assign valid     = out_valid;
    assign data      = out_data;
    assign occupancy = OCC_WIDTH'(out_valid) + OCC_WIDTH'(skid_valid);

endmodule

// File: rtl/fifo_stream_reader.sv
// Pops a registered-output FIFO and re-presents its words as a valid/ready stream.
//   state | meaning
//   IDLE  | no reads issued; waiting for enable
//   RUN   | popping the FIFO whenever the holding buffer has room
//   DRAIN | enable dropped; finishing the in-flight and held words
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int FIFO_DATA_WIDTH = 8,
    parameter int COUNT_WIDTH     = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       enable,
    input  logic                       fifo_empty,
    output logic                       fifo_read,
    input  logic [FIFO_DATA_WIDTH-1:0] fifo_read_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [FIFO_DATA_WIDTH-1:0] m_data,
    output logic                       busy,
    output logic [COUNT_WIDTH-1:0]     word_count
);

    reader_state_t          state, state_next;
    logic                   pending;
    logic                   pop;
    logic [OCC_WIDTH-1:0]   occupancy;

    assign pop = m_valid & m_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (enable) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (!enable) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (enable) begin
                    state_next = ST_RUN;
                end else if (!pending && (occupancy == '0)) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Gated by reset_n so no pop escapes while the block is held in reset.
    always_comb begin
        fifo_read = reset_n
                  & (state == ST_RUN)
                  & enable
                  & ~fifo_empty
                  & has_room(occupancy, pending, pop);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pending    <= 1'b0;
            word_count <= '0;
        end else begin
            pending <= fifo_read;
            if (pop) word_count <= word_count + COUNT_WIDTH'(1);
        end
    end

    fifo_skid_buffer #(
        .DATA_WIDTH (FIFO_DATA_WIDTH)
    ) u_hold (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (pending),
        .push_data (fifo_read_data),
        .ready     (m_ready),
        .valid     (m_valid),
        .data      (m_data),
        .occupancy (occupancy)
    );

    assign busy = pending | (occupancy != '0);

endmodule

// File: doc/fifo_stream_reader.md
FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 Parameter FIFO_DATA_WIDTH, default 8: width of FIFO read data and stream data.
REQ-002 Parameter COUNT_WIDTH, default 16: width of transferred-word counter.
REQ-003 clk  input  1: single clock; all state updates on rising edge.
REQ-004 reset_n  input  1: synchronous, active-low reset; sampled on rising edge of clk.
REQ-005 enable  input  1: high permits new FIFO reads; low stops new reads and drains held words.
REQ-006 fifo_empty  input  1: empty flag of the upstream FIFO.
REQ-007 fifo_read  output  1: FIFO pop request; combinational.
REQ-008 fifo_read_data  input  FIFO_DATA_WIDTH: FIFO registered read data, valid the cycle after a pop.
REQ-009 m_valid  output  1: downstream word valid; registered.
REQ-010 m_ready  input  1: downstream accepts the word when m_valid & m_ready.
REQ-011 m_data  output  FIFO_DATA_WIDTH: downstream word; registered.
REQ-012 busy  output  1: high while a pop is in flight or any word is held.
REQ-013 word_count  output  COUNT_WIDTH: number of downstream transfers since reset.

Function
REQ-014 Internal state: pending flag (pop issued last cycle), 2-entry holding buffer (output register plus skid register), occupancy 0..2, FSM {IDLE, RUN, DRAIN}.
REQ-015 pop = m_valid & m_ready; fifo_read = (state==RUN) & enable & !fifo_empty & (occupancy + pending - pop) < 2.
REQ-016 Read latency: a word popped in cycle N is captured from fifo_read_data at the end of cycle N+1 (pending=1 during N+1).
REQ-017 Captured word goes to the output register if it is empty after this cycle's pop, otherwise to the skid register.
REQ-018 On pop with skid occupied, skid word moves to the output register in the same edge; order strictly FIFO.
REQ-019 m_valid = (occupancy != 0); m_data and m_valid are held stable while m_valid & !m_ready.
REQ-020 Sustained throughput: 1 word/cycle when FIFO non-empty and m_ready constantly high.
REQ-021 m_ready low: at most 2 words held plus none in flight; no word is ever dropped or duplicated.
REQ-022 FSM IDLE -> RUN when enable=1; RUN -> DRAIN when enable=0; DRAIN -> IDLE when pending=0 and occupancy=0; DRAIN -> RUN when enable=1.
REQ-023 In IDLE and DRAIN fifo_read=0; an in-flight word at RUN->DRAIN is still captured and delivered.
REQ-024 fifo_read is never asserted while fifo_empty=1.
REQ-025 word_count increments by 1 per pop, wraps modulo 2^COUNT_WIDTH.
REQ-026 busy = pending | (occupancy != 0).

Reset
REQ-027 reset_n=0 at a rising edge forces state=IDLE, pending=0, occupancy=0, m_valid=0, m_data=0, word_count=0, busy=0.
REQ-028 fifo_read=0 during any cycle with reset_n=0.
REQ-029 Reset mid-transfer discards held and in-flight words; the upstream FIFO is reset by its own owner, not by this block.

Structure
REQ-030 FSM state enum and the 2-entry depth constant belong in shared package fifo_pkg.
REQ-031 One sub-module is natural: fifo_skid_buffer (2-entry holding buffer with valid/ready output); FSM, pop issue and counter stay in the top.

Verification
REQ-032 FIFO holds 0x11,0x22,0x33, enable=1, m_ready=1 -> m_data 0x11,0x22,0x33 on 3 consecutive cycles starting 2 cycles after enable; word_count=3.
REQ-033 FIFO holds 5 words, m_ready=0 -> exactly 2 fifo_read pulses, m_valid=1 with first word stable; m_ready=1 then delivers all 5 in order.
REQ-034 enable dropped the cycle after a pop of 0x5A -> 0x5A still delivered, FSM reaches IDLE, busy=0, no further fifo_read.
REQ-035 m_ready toggling 1,0,1,0 with 8 words queued -> 8 words delivered in order, no duplicates or gaps, word_count=8.
REQ-036 reset_n=0 while 2 words held -> next cycle m_valid=0, m_data=0, word_count=0, busy=0, fifo_read=0.
REQ-037 word_count preset to 0xFFFF by 65535 transfers plus 1 more -> word_count=0x0000.
